// File: rtl/gth_symbol_packer.sv
// Gearbox from NUM_CH parallel SYM_W-bit symbols per cycle to one GT word of RATIO
// slots per channel, with idle substitution, test-pattern modes and status counters.
module gth_symbol_packer #(
    parameter int              NUM_CH   = 3,
    parameter int              SYM_W    = 10,
    parameter int              RATIO    = 2,
    parameter logic [SYM_W-1:0] IDLE_SYM = 10'h354,
    parameter logic [SYM_W-1:0] CLK_PAT  = 10'h3E0,
    localparam int             PH_W     = (RATIO > 1) ? $clog2(RATIO) : 1,
    localparam int             WORD_W   = NUM_CH * SYM_W * RATIO
) (
    input  logic                    txoutclk_internal,
    input  logic                    gtwiz_reset_clk_freerun_in,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    input  logic [NUM_CH*SYM_W-1:0] in_sym,
    input  logic                    align,
    input  logic                    clear_status,
    input  logic                    out_full,
    output logic [WORD_W-1:0]       out_word,
    output logic                    out_valid,
    output logic [PH_W-1:0]         phase,
    output logic [15:0]             underrun_cnt,
    output logic                    overflow
);

    localparam logic [PH_W-1:0] LAST_PH = PH_W'(RATIO - 1);
    localparam logic [15:0]     CNT_MAX = 16'hFFFF;

    function automatic logic [6:0] prbs_seed(input int c);
        return 7'h7F ^ c[6:0];
    endfunction

    // Returns {next_state, symbol}: SYM_W steps of x^7+x^6+1, symbol bit k = feedback of step k.
    function automatic logic [SYM_W+6:0] prbs_sym(input logic [6:0] seed);
        logic [6:0]       st;
        logic [SYM_W-1:0] sym;
        logic             nb;
        st  = seed;
        sym = '0;
        for (int k = 0; k < SYM_W; k++) begin
            nb     = st[6] ^ st[5];
            sym[k] = nb;
            st     = {st[5:0], nb};
        end
        return {st, sym};
    endfunction

    logic [PH_W-1:0]   phase_r;
    logic [1:0]        active_mode_r;
    logic [1:0]        cur_mode_s;
    logic [WORD_W-1:0] shadow_r;
    logic [WORD_W-1:0] shadow_nxt_s;
    logic [WORD_W-1:0] out_word_r;
    logic              out_valid_r;
    logic              overflow_r;
    logic [15:0]       underrun_cnt_r;
    logic              underrun_s;
    logic              last_s;
    logic [6:0]        lfsr_r     [NUM_CH];
    logic [6:0]        lfsr_nxt_s [NUM_CH];
    logic [SYM_W+6:0]  prbs_s     [NUM_CH];
    logic [SYM_W-1:0]  sym_s      [NUM_CH];

    // Mode is taken live on slot 0 so the whole word uses one mode
    always_comb begin
        if (phase_r == '0) begin
            cur_mode_s = mode;
        end else begin
            cur_mode_s = active_mode_r;
        end
        last_s     = (phase_r == LAST_PH);
        underrun_s = (cur_mode_s == 2'd0) && !in_valid && !align;
    end

    // Per-channel symbol source selection
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            prbs_s[c]     = prbs_sym(lfsr_r[c]);
            lfsr_nxt_s[c] = prbs_s[c][SYM_W+6:SYM_W];
            case (cur_mode_s)
                2'd0: begin
                    if (in_valid) begin
                        sym_s[c] = in_sym[c*SYM_W +: SYM_W];
                    end else begin
                        sym_s[c] = IDLE_SYM;
                    end
                end
                2'd1:    sym_s[c] = IDLE_SYM;
                2'd2:    sym_s[c] = CLK_PAT;
                2'd3:    sym_s[c] = prbs_s[c][SYM_W-1:0];
                default: sym_s[c] = IDLE_SYM;
            endcase
        end
    end

    // Shadow word with the current symbols written into slot phase
    always_comb begin
        shadow_nxt_s = shadow_r;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < RATIO; s++) begin
                if (PH_W'(s) == phase_r) begin
                    shadow_nxt_s[(c*RATIO+s)*SYM_W +: SYM_W] = sym_s[c];
                end else begin
                    shadow_nxt_s[(c*RATIO+s)*SYM_W +: SYM_W] = shadow_r[(c*RATIO+s)*SYM_W +: SYM_W];
                end
            end
        end
    end

    // Slot counter, shadow word and completed-word register
    always_ff @(posedge txoutclk_internal or posedge gtwiz_reset_clk_freerun_in) begin
        if (gtwiz_reset_clk_freerun_in) begin
            phase_r     <= '0;
            shadow_r    <= '0;
            out_word_r  <= '0;
            out_valid_r <= 1'b0;
        end else if (align) begin
            phase_r     <= '0;
            shadow_r    <= '0;
            out_valid_r <= 1'b0;
        end else begin
            shadow_r    <= shadow_nxt_s;
            out_valid_r <= last_s;
            if (last_s) begin
                phase_r    <= '0;
                out_word_r <= shadow_nxt_s;
            end else begin
                phase_r <= phase_r + PH_W'(1);
            end
        end
    end

    // Latch the word's mode on slot 0
    always_ff @(posedge txoutclk_internal or posedge gtwiz_reset_clk_freerun_in) begin
        if (gtwiz_reset_clk_freerun_in) begin
            active_mode_r <= 2'd0;
        end else if (phase_r == '0) begin
            active_mode_r <= cur_mode_s;
        end
    end

    // PRBS7 generators: reseed on align, advance only while in PRBS mode
    always_ff @(posedge txoutclk_internal or posedge gtwiz_reset_clk_freerun_in) begin
        if (gtwiz_reset_clk_freerun_in) begin
            for (int c = 0; c < NUM_CH; c++) lfsr_r[c] <= prbs_seed(c);
        end else if (align) begin
            for (int c = 0; c < NUM_CH; c++) lfsr_r[c] <= prbs_seed(c);
        end else if (cur_mode_s == 2'd3) begin
            for (int c = 0; c < NUM_CH; c++) lfsr_r[c] <= lfsr_nxt_s[c];
        end
    end

    // Status: saturating underrun count and sticky overflow, clear has priority
    always_ff @(posedge txoutclk_internal or posedge gtwiz_reset_clk_freerun_in) begin
        if (gtwiz_reset_clk_freerun_in) begin
            underrun_cnt_r <= 16'd0;
            overflow_r     <= 1'b0;
        end else if (clear_status) begin
            underrun_cnt_r <= 16'd0;
            overflow_r     <= 1'b0;
        end else begin
            if (underrun_s && (underrun_cnt_r != CNT_MAX)) begin
                underrun_cnt_r <= underrun_cnt_r + 16'd1;
            end
            if (out_valid_r && out_full) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign out_word     = out_word_r;
    assign out_valid    = out_valid_r;
    assign phase        = phase_r;
    assign underrun_cnt = underrun_cnt_r;
    assign overflow     = overflow_r;

endmodule

// File: tb/tb_gth_symbol_packer.sv
// Bench for gth_symbol_packer (default parameters): table of words fed through a
// strobe scoreboard, plus hand sequences for align, saturation, overflow, reset, PRBS7.
module tb_gth_symbol_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode;
    logic        in_valid;
    logic [29:0] in_sym;
    logic        align;
    logic        clear_status;
    logic        out_full;
    logic [59:0] out_word;
    logic        out_valid;
    logic [0:0]  phase;
    logic [15:0] underrun_cnt;
    logic        overflow;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] cyc = 32'd0;
    logic        sb_en = 1'b0;
    int          exp_ur;

    typedef struct packed {
        logic [59:0] word;
        logic [31:0] due;
    } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    typedef struct packed {
        logic [3:0]  modes;
        logic [1:0]  valid;
        logic [59:0] syms;
        logic [59:0] expw;
    } vec_t;
    vec_t vecs [10];
    vec_t v_tmp;

    gth_symbol_packer dut (
        .txoutclk_internal          (clk),
        .gtwiz_reset_clk_freerun_in (rst),
        .mode                       (mode),
        .in_valid                   (in_valid),
        .in_sym                     (in_sym),
        .align                      (align),
        .clear_status               (clear_status),
        .out_full                   (out_full),
        .out_word                   (out_word),
        .out_valid                  (out_valid),
        .phase                      (phase),
        .underrun_cnt               (underrun_cnt),
        .overflow                   (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, expv);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected word at its due cycle
    always @(negedge clk) begin
        if (sb_en) begin
            while (sb_q.size() > 0 && cyc > sb_q[0].due) begin
                check("missed_strobe", 64'(cyc), 64'(sb_q[0].due));
                void'(sb_q.pop_front());
            end
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_strobe", 64'(out_valid), 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("strobe_word", 64'(out_word), 64'(mon_e.word));
                    check("strobe_cycle", 64'(cyc), 64'(mon_e.due));
                end
            end
        end
    end

    task automatic drive(input logic [1:0] m, input logic v, input logic [29:0] s,
                         input logic al, input logic clr, input logic full);
        mode = m; in_valid = v; in_sym = s; align = al; clear_status = clr; out_full = full;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_word(input vec_t v, input logic push, input logic full,
                              input logic hold_chk, input logic [59:0] prev);
        logic [29:0] s3;
        sb_t         e;
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 3; c++) s3[c*10 +: 10] = v.syms[(c*2+s)*10 +: 10];
            if (push && s == 1) begin
                e.word = v.expw;
                e.due  = cyc + 32'd1;
                sb_q.push_back(e);
            end
            drive(v.modes[s*2 +: 2], v.valid[s], s3, 1'b0, 1'b0, full);
            if (hold_chk && s == 0) begin
                check("hold_word", 64'(out_word), 64'(prev));
                check("hold_valid", 64'(out_valid), 64'd0);
                check("phase_mid", 64'(phase), 64'd1);
            end
        end
    endtask

    function automatic logic [59:0] prbs_model();
        logic [59:0] w;
        logic [6:0]  st;
        logic        b;
        w = '0;
        for (int c = 0; c < 3; c++) begin
            st = 7'h7F ^ 7'(c);
            for (int n = 0; n < 20; n++) begin
                b = st[6] ^ st[5];
                w[(c*2 + n/10)*10 + (n%10)] = b;
                st = {st[5:0], b};
            end
        end
        return w;
    endfunction

    initial begin
        mode = 2'd0; in_valid = 1'b0; in_sym = 30'd0; align = 1'b0;
        clear_status = 1'b0; out_full = 1'b0;

        vecs[0] = '{modes: 4'b0000, valid: 2'b11,
                    syms: {10'h202, 10'h201, 10'h102, 10'h101, 10'h002, 10'h001},
                    expw: {10'h202, 10'h201, 10'h102, 10'h101, 10'h002, 10'h001}};
        vecs[1] = '{modes: 4'b0000, valid: 2'b11,
                    syms: {10'h30F, 10'h0F0, 10'h2AA, 10'h155, 10'h000, 10'h3FF},
                    expw: {10'h30F, 10'h0F0, 10'h2AA, 10'h155, 10'h000, 10'h3FF}};
        vecs[2] = '{modes: 4'b0000, valid: 2'b01,
                    syms: {10'h3AB, 10'h056, 10'h3AB, 10'h034, 10'h3AB, 10'h012},
                    expw: {10'h354, 10'h056, 10'h354, 10'h034, 10'h354, 10'h012}};
        vecs[3] = '{modes: 4'b0000, valid: 2'b00, syms: {6{10'h111}}, expw: {6{10'h354}}};
        vecs[4] = '{modes: 4'b0101, valid: 2'b11, syms: {6{10'h0AA}}, expw: {6{10'h354}}};
        vecs[5] = '{modes: 4'b1010, valid: 2'b11, syms: {6{10'h0AA}}, expw: {6{10'h3E0}}};
        vecs[6] = '{modes: 4'b1000, valid: 2'b11,
                    syms: {10'h2C5, 10'h1C4, 10'h2B3, 10'h1B2, 10'h2A1, 10'h1A0},
                    expw: {10'h2C5, 10'h1C4, 10'h2B3, 10'h1B2, 10'h2A1, 10'h1A0}};
        vecs[7] = '{modes: 4'b1010, valid: 2'b11, syms: {6{10'h0AA}}, expw: {6{10'h3E0}}};
        vecs[8] = '{modes: 4'b0001, valid: 2'b00, syms: {6{10'h2F2}}, expw: {6{10'h354}}};
        vecs[9] = '{modes: 4'b0000, valid: 2'b11,
                    syms: {10'h005, 10'h004, 10'h003, 10'h002, 10'h001, 10'h000},
                    expw: {10'h005, 10'h004, 10'h003, 10'h002, 10'h001, 10'h000}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_word", 64'(out_word), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_phase", 64'(phase), 64'd0);
        check("rst_underrun", 64'(underrun_cnt), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);

        // Table of words through the scoreboard
        rst = 1'b0;
        sb_en = 1'b1;
        exp_ur = 0;
        for (int i = 0; i < 10; i++) begin
            apply_word(vecs[i], 1'b1, 1'b0, (i > 0), (i > 0) ? vecs[i-1].expw : 60'd0);
            if (vecs[i].modes[1:0] == 2'd0) begin
                exp_ur += (vecs[i].valid[0] ? 0 : 1) + (vecs[i].valid[1] ? 0 : 1);
            end
        end
        check("underrun_table", 64'(underrun_cnt), 64'(exp_ur));

        // Align on the completion cycle: partial word dropped, no strobe
        drive(2'd0, 1'b1, {10'h3F3, 10'h3F2, 10'h3F1}, 1'b0, 1'b0, 1'b0);
        drive(2'd0, 1'b1, {10'h3E3, 10'h3E2, 10'h3E1}, 1'b1, 1'b0, 1'b0);
        check("align_ph1_phase", 64'(phase), 64'd0);
        check("align_ph1_valid", 64'(out_valid), 64'd0);
        v_tmp = '{modes: 4'b0000, valid: 2'b11,
                  syms: {10'h0C6, 10'h0C5, 10'h0C4, 10'h0C3, 10'h0C2, 10'h0C1},
                  expw: {10'h0C6, 10'h0C5, 10'h0C4, 10'h0C3, 10'h0C2, 10'h0C1}};
        apply_word(v_tmp, 1'b1, 1'b0, 1'b0, 60'd0);
        // Align on slot 0
        drive(2'd0, 1'b1, {10'h3D3, 10'h3D2, 10'h3D1}, 1'b1, 1'b0, 1'b0);
        check("align_ph0_phase", 64'(phase), 64'd0);
        v_tmp = '{modes: 4'b0000, valid: 2'b11,
                  syms: {10'h1E6, 10'h1E5, 10'h1E4, 10'h1E3, 10'h1E2, 10'h1E1},
                  expw: {10'h1E6, 10'h1E5, 10'h1E4, 10'h1E3, 10'h1E2, 10'h1E1}};
        apply_word(v_tmp, 1'b1, 1'b0, 1'b0, 60'd0);
        drive(2'd0, 1'b1, 30'd0, 1'b1, 1'b0, 1'b0);
        check("sb_drained_1", 64'(sb_q.size()), 64'd0);
        sb_en = 1'b0;

        // Underrun saturation and clear priority
        drive(2'd0, 1'b1, 30'd0, 1'b0, 1'b1, 1'b0);
        check("ur_cleared", 64'(underrun_cnt), 64'd0);
        repeat (65534) drive(2'd0, 1'b0, 30'd0, 1'b0, 1'b0, 1'b0);
        check("ur_fffe", 64'(underrun_cnt), 64'hFFFE);
        repeat (3) drive(2'd0, 1'b0, 30'd0, 1'b0, 1'b0, 1'b0);
        check("ur_saturated", 64'(underrun_cnt), 64'hFFFF);
        drive(2'd0, 1'b0, 30'd0, 1'b0, 1'b1, 1'b0);
        check("ur_clear_prio", 64'(underrun_cnt), 64'd0);

        // Overflow: sticky, cleared, clear wins over simultaneous set
        drive(2'd0, 1'b1, 30'd0, 1'b1, 1'b0, 1'b0);
        drive(2'd0, 1'b1, {10'h321, 10'h123, 10'h0F1}, 1'b0, 1'b0, 1'b1);
        drive(2'd0, 1'b1, {10'h2B2, 10'h1B1, 10'h0B0}, 1'b0, 1'b0, 1'b1);
        check("ovf_strobe", 64'(out_valid), 64'd1);
        check("ovf_not_yet", 64'(overflow), 64'd0);
        drive(2'd0, 1'b1, {10'h321, 10'h123, 10'h0F1}, 1'b0, 1'b0, 1'b1);
        check("ovf_set", 64'(overflow), 64'd1);
        repeat (3) drive(2'd0, 1'b1, {10'h2B2, 10'h1B1, 10'h0B0}, 1'b0, 1'b0, 1'b0);
        check("ovf_sticky", 64'(overflow), 64'd1);
        drive(2'd0, 1'b1, {10'h321, 10'h123, 10'h0F1}, 1'b0, 1'b1, 1'b1);
        check("ovf_clear_prio", 64'(overflow), 64'd0);
        drive(2'd0, 1'b1, {10'h2B2, 10'h1B1, 10'h0B0}, 1'b0, 1'b0, 1'b1);
        check("ovf_no_strobe", 64'(overflow), 64'd0);
        drive(2'd0, 1'b0, {10'h321, 10'h123, 10'h0F1}, 1'b0, 1'b0, 1'b1);
        check("ovf_set_again", 64'(overflow), 64'd1);
        check("pre_rst_underrun", 64'(underrun_cnt), 64'd1);
        check("pre_rst_word", 64'(out_word),
              64'({10'h2B2, 10'h321, 10'h1B1, 10'h123, 10'h0B0, 10'h0F1}));

        // Reset mid-word clears outputs at once; first word after release starts at slot 0
        rst = 1'b1;
        #1;
        check("mid_rst_word", 64'(out_word), 64'd0);
        check("mid_rst_phase", 64'(phase), 64'd0);
        check("mid_rst_underrun", 64'(underrun_cnt), 64'd0);
        check("mid_rst_overflow", 64'(overflow), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb_en = 1'b1;
        v_tmp = '{modes: 4'b0000, valid: 2'b11,
                  syms: {10'h2E6, 10'h1E5, 10'h2D4, 10'h1D3, 10'h2C2, 10'h1C1},
                  expw: {10'h2E6, 10'h1E5, 10'h2D4, 10'h1D3, 10'h2C2, 10'h1C1}};
        apply_word(v_tmp, 1'b1, 1'b0, 1'b0, 60'd0);
        drive(2'd0, 1'b1, 30'd0, 1'b1, 1'b0, 1'b0);
        check("sb_drained_2", 64'(sb_q.size()), 64'd0);
        sb_en = 1'b0;

        // PRBS7 from reset, then align reseeds and repeats the same word
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb_en = 1'b1;
        v_tmp = '{modes: 4'b1111, valid: 2'b11, syms: {6{10'h3C3}}, expw: prbs_model()};
        apply_word(v_tmp, 1'b1, 1'b0, 1'b0, 60'd0);
        check("prbs_ch0_slot0", 64'(out_word[9:0]), 64'h040);
        drive(2'd3, 1'b1, 30'd0, 1'b1, 1'b0, 1'b0);
        check("prbs_align_phase", 64'(phase), 64'd0);
        apply_word(v_tmp, 1'b1, 1'b0, 1'b0, 60'd0);
        check("prbs_reseed_ch0", 64'(out_word[9:0]), 64'h040);
        drive(2'd0, 1'b1, 30'd0, 1'b1, 1'b0, 1'b0);
        check("sb_drained_3", 64'(sb_q.size()), 64'd0);
        sb_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
